// File: rtl/photon_pkg.sv
// photon_pkg: shared opcodes, core state encoding and the driver FSM state type for the photon hash slice.
package photon_pkg;

  localparam int PHOTON_WORDS = 8;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_WRITE = 3'd1,
    OP_READ  = 3'd2,
    OP_HASH  = 3'd3,
    OP_CHECK = 3'd4
  } photon_opcode;

  typedef enum logic [1:0] {
    PH_WAIT    = 2'd0,
    PH_ABSORB  = 2'd1,
    PH_PERMUTE = 2'd2,
    PH_SQUEEZE = 2'd3
  } photon_state;

  typedef enum logic [2:0] {
    DRV_IDLE   = 3'd0,
    DRV_LOAD   = 3'd1,
    DRV_KICK   = 3'd2,
    DRV_SETTLE = 3'd3,
    DRV_POLL   = 3'd4,
    DRV_READ   = 3'd5,
    DRV_DONE   = 3'd6
  } photon_drv_state_t;

  function automatic logic [31:0] word_of(input logic [255:0] blk, input logic [2:0] idx);
    return blk[{idx, 5'b00000} +: 32];
  endfunction

endpackage

// File: rtl/photon_drv_watchdog.sv
// photon_drv_watchdog: counts consecutive POLL cycles and flags when the limit is reached.
// Only exists when PHOTON_DRV_TIMEOUT_EN is defined.
`ifdef PHOTON_DRV_TIMEOUT_EN
module photon_drv_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // Counter restarts whenever the driver leaves POLL and saturates at the limit.
  always_comb begin
    count_d = count_q;
    if (!en_i) begin
      count_d = '0;
    end else if (count_q != LIMIT) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = en_i && (count_q == LIMIT);

endmodule
`endif

// File: rtl/photon_driver.sv
// photon_driver: sole bus master of the photon core; loads a 256-bit block, hashes, polls and returns the digest.
// Define PHOTON_DRV_TIMEOUT_EN to add a POLL watchdog that aborts with err and an all-zero digest.
module photon_driver
  import photon_pkg::*;
#(
  parameter int WORDS         = PHOTON_WORDS,
  parameter int SETTLE_CYCLES = 2
`ifdef PHOTON_DRV_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [255:0] msg_data,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] dig_data,
  output logic         busy,
  output logic         err,
  output logic [2:0]   ph_opcode,
  output logic [2:0]   ph_addr,
  output logic [31:0]  ph_data_in,
  input  logic [31:0]  ph_data_out,
  input  logic         ph_ready
);

  localparam logic [2:0] LAST_WORD = 3'(WORDS - 1);
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] LAST_SETTLE = SW'(SETTLE_CYCLES - 1);

  photon_drv_state_t state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [255:0]      msg_q, msg_d;
  logic [255:0]      dig_q, dig_d;
  photon_opcode      op_q, op_d;
  logic [2:0]        addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              pollDone;

  assign pollDone = ph_data_out[0] & ph_ready;

`ifdef PHOTON_DRV_TIMEOUT_EN
  logic wdFire;
  logic err_q;

  photon_drv_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .en_i     (state_q == DRV_POLL),
    .expired_o(wdFire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (state_q == DRV_POLL && !pollDone && wdFire) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Next-state logic; the bus outputs are then derived from the next state so they are registered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    msg_d    = msg_q;
    dig_d    = dig_q;
    op_d     = OP_NONE;
    addr_d   = 3'd0;
    wdata_d  = 32'd0;

    unique case (state_q)
      DRV_IDLE: begin
        if (msg_valid) begin
          msg_d   = msg_data;
          cnt_d   = 3'd0;
          state_d = DRV_LOAD;
        end
      end
      DRV_LOAD: begin
        if (cnt_q == LAST_WORD) begin
          cnt_d   = 3'd0;
          state_d = DRV_KICK;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DRV_KICK: begin
        if (op_q == OP_HASH) begin
          settle_d = '0;
          state_d  = DRV_SETTLE;
        end
      end
      DRV_SETTLE: begin
        if (settle_q == LAST_SETTLE) begin
          settle_d = '0;
          state_d  = DRV_POLL;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      DRV_POLL: begin
        if (pollDone) begin
          cnt_d   = 3'd0;
          state_d = DRV_READ;
        end
`ifdef PHOTON_DRV_TIMEOUT_EN
        else if (wdFire) begin
          dig_d   = '0;
          state_d = DRV_DONE;
        end
`endif
      end
      DRV_READ: begin
        dig_d[{cnt_q, 5'b00000} +: 32] = ph_data_out;
        if (cnt_q == LAST_WORD) begin
          cnt_d   = 3'd0;
          state_d = DRV_DONE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      DRV_DONE: begin
        if (dig_ready) begin
          state_d = DRV_IDLE;
        end
      end
      default: state_d = DRV_IDLE;
    endcase

    // HASH is only launched when the core reported idle on the previous cycle.
    case (state_d)
      DRV_LOAD: begin
        op_d    = OP_WRITE;
        addr_d  = cnt_d;
        wdata_d = word_of(msg_d, cnt_d);
      end
      DRV_KICK: begin
        if (ph_ready) begin
          op_d = OP_HASH;
        end
      end
      DRV_POLL: op_d = OP_CHECK;
      DRV_READ: begin
        op_d   = OP_READ;
        addr_d = cnt_d;
      end
      default: op_d = OP_NONE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DRV_IDLE;
      cnt_q    <= 3'd0;
      settle_q <= '0;
      msg_q    <= '0;
      dig_q    <= '0;
      op_q     <= OP_NONE;
      addr_q   <= 3'd0;
      wdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      msg_q    <= msg_d;
      dig_q    <= dig_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign msg_ready  = (state_q == DRV_IDLE);
  assign dig_valid  = (state_q == DRV_DONE);
  assign busy       = (state_q != DRV_IDLE);
  assign dig_data   = dig_q;
  assign ph_opcode  = op_q;
  assign ph_addr    = addr_q;
  assign ph_data_in = wdata_q;

endmodule

// File: tb/tb_photon_driver.sv
// tb_photon_driver: table-driven scoreboard bench for photon_driver with a behavioural photon core stub.
// Define PHOTON_DRV_TIMEOUT_EN to also exercise the POLL watchdog.
module tb_photon_driver;
  import photon_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         msg_valid;
  logic         msg_ready;
  logic [255:0] msg_data;
  logic         dig_valid;
  logic         dig_ready;
  logic [255:0] dig_data;
  logic         busy;
  logic         err;
  logic [2:0]   ph_opcode;
  logic [2:0]   ph_addr;
  logic [31:0]  ph_data_in;
  logic [31:0]  ph_data_out;
  logic         ph_ready;

  int checks = 0;
  int failures = 0;
  logic [255:0] expQ[$];

  photon_driver #(
    .WORDS(8),
    .SETTLE_CYCLES(2)
`ifdef PHOTON_DRV_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .msg_data   (msg_data),
    .dig_valid  (dig_valid),
    .dig_ready  (dig_ready),
    .dig_data   (dig_data),
    .busy       (busy),
    .err        (err),
    .ph_opcode  (ph_opcode),
    .ph_addr    (ph_addr),
    .ph_data_in (ph_data_in),
    .ph_data_out(ph_data_out),
    .ph_ready   (ph_ready)
  );

  always #5 clk = ~clk;

  // Stand-in hash: any fixed word mix works, the driver only moves data.
  function automatic logic [255:0] digestOf(input logic [255:0] blk);
    logic [255:0] r;
    logic [31:0]  w;
    logic [31:0]  n;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      w = blk[32*i +: 32];
      n = blk[32*((i + 1) % 8) +: 32];
      r[32*i +: 32] = {w[12:0], w[31:13]} ^ n ^ (32'h9E3779B9 * 32'(i + 1));
    end
    return r;
  endfunction

  function automatic logic [255:0] mkMsg(input logic [31:0] base, input logic [31:0] step);
    logic [255:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[32*i +: 32] = base + step * 32'(i);
    return m;
  endfunction

  // Core stub: ready drops after HASH (optionally after a hold), stays low busyCfg cycles.
  logic         stubReady;
  logic [255:0] coreInBlk;
  logic [255:0] coreOutBlk;
  int holdCfg = 0;
  int busyCfg = 1;
  int holdLeft;
  int busyLeft;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stubReady  <= 1'b1;
      holdLeft   <= 0;
      busyLeft   <= 0;
      coreInBlk  <= '0;
      coreOutBlk <= '0;
    end else begin
      if (ph_opcode == OP_WRITE) coreInBlk[32*ph_addr +: 32] <= ph_data_in;
      if (ph_opcode == OP_HASH) begin
        coreOutBlk <= digestOf(coreInBlk);
        holdLeft   <= holdCfg;
        busyLeft   <= busyCfg;
        stubReady  <= (holdCfg > 0);
      end else if (holdLeft > 0) begin
        holdLeft <= holdLeft - 1;
        if (holdLeft == 1) stubReady <= 1'b0;
      end else if (busyLeft > 0) begin
        busyLeft <= busyLeft - 1;
        if (busyLeft == 1) stubReady <= 1'b1;
      end
    end
  end

  assign ph_ready    = stubReady;
  assign ph_data_out = (ph_opcode == OP_READ)  ? coreOutBlk[32*ph_addr +: 32] :
                       (ph_opcode == OP_CHECK) ? {31'd0, stubReady} : 32'd0;

  // Bus monitor: counts accepted blocks and flags protocol misuse.
  int acceptCount = 0;
  int writeCount = 0;
  int hashCount = 0;
  int writeOrderErr = 0;
  int writeWhileBusy = 0;
  int hashWhileBusy = 0;
  int readWhileBusy = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (msg_valid && msg_ready) acceptCount <= acceptCount + 1;
      if (ph_opcode == OP_WRITE) begin
        writeCount <= writeCount + 1;
        if (!stubReady) writeWhileBusy <= writeWhileBusy + 1;
        if (ph_addr != 3'(writeCount % 8)) writeOrderErr <= writeOrderErr + 1;
      end
      if (ph_opcode == OP_HASH) begin
        hashCount <= hashCount + 1;
        if (!stubReady) hashWhileBusy <= hashWhileBusy + 1;
      end
      if (ph_opcode == OP_READ && !stubReady) readWhileBusy <= readWhileBusy + 1;
    end
  end

  task automatic checkVal(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one block and push its expected digest when it is accepted.
  task automatic applyStimulus(input logic [255:0] msg, input logic [255:0] expDig);
    int n;
    @(negedge clk);
    msg_data  = msg;
    msg_valid = 1'b1;
    n = 0;
    while (!msg_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkVal("accept_ready", msg_ready, 1);
    if (msg_ready) begin
      expQ.push_back(expDig);
      @(posedge clk);
      #1;
    end
    msg_valid = 1'b0;
  endtask

  task automatic waitDigest(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!dig_valid && lat < 400);
  endtask

  // Wait for the digest, compare against the scoreboard, optionally stall, then retire it.
  task automatic checkOutput(input string name, input int expLat, input int holdCyc);
    int lat;
    int unstable;
    logic [255:0] expDig;
    logic [255:0] snap;
    waitDigest(lat);
    checkVal({name, ":dig_valid"}, dig_valid, 1);
    if (!dig_valid) begin
      if (expQ.size() > 0) expQ.delete(0);
      return;
    end
    checkVal({name, ":latency"}, lat, expLat);
    checkVal({name, ":scoreboard"}, expQ.size() > 0, 1);
    expDig = (expQ.size() > 0) ? expQ.pop_front() : '0;
    checkVal({name, ":dig_data"}, dig_data, expDig);
    snap = dig_data;
    unstable = 0;
    for (int i = 0; i < holdCyc; i++) begin
      @(negedge clk);
      if (dig_valid !== 1'b1 || dig_data !== snap || msg_ready !== 1'b0) unstable++;
    end
    if (holdCyc > 0) checkVal({name, ":hold_stable"}, unstable, 0);
    dig_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dig_ready = 1'b0;
    checkVal({name, ":valid_drop"}, dig_valid, 0);
  endtask

  typedef struct {
    string        name;
    logic [255:0] msg;
    int           holdCyc;
    int           busyCyc;
    logic [255:0] expDig;
    int           expLat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int wBefore;
    int hBefore;
    int aBefore;
    int n;
    int readyLeak;
    int lat;
    logic [255:0] msgA;
    logic [255:0] msgB;
    logic [255:0] rnd;

    rst       = 1'b0;
    msg_valid = 1'b0;
    msg_data  = '0;
    dig_ready = 1'b0;

    // Latency = 20 + P, P = POLL cycles = max(1, busy-1) with no hold.
    for (int i = 0; i < 8; i++) rnd[32*i +: 32] = $urandom;
    vecs[0] = '{"v0_count",  mkMsg(32'h0, 32'h1), 0, 5, '0, 24};
    vecs[1] = '{"v1_mixed",  mkMsg(32'hDEADBEEF, 32'h01234567), 0, 1, '0, 21};
    vecs[2] = '{"v2_ones",   mkMsg(32'hFFFFFFFF, 32'h0), 0, 2, '0, 21};
    vecs[3] = '{"v3_random", rnd, 0, 3, '0, 22};
    vecs[4] = '{"v4_msb",    mkMsg(32'h80000000, 32'h11111111), 0, 10, '0, 29};
    vecs[5] = '{"v5_slow",   mkMsg(32'hCAFE0000, 32'h3), 2, 50, '0, 71};
    for (int i = 0; i < 6; i++) vecs[i].expDig = digestOf(vecs[i].msg);

    #1 rst = 1'b1;
    #3;
    checkVal("rst:dig_valid", dig_valid, 0);
    checkVal("rst:dig_data", dig_data, 0);
    checkVal("rst:busy", busy, 0);
    checkVal("rst:err", err, 0);
    checkVal("rst:ph_opcode", ph_opcode, OP_NONE);
    checkVal("rst:ph_addr", ph_addr, 0);
    checkVal("rst:ph_data_in", ph_data_in, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkVal("rst:msg_ready", msg_ready, 1);

    for (int i = 0; i < 6; i++) begin
      holdCfg = vecs[i].holdCyc;
      busyCfg = vecs[i].busyCyc;
      wBefore = writeCount;
      hBefore = hashCount;
      applyStimulus(vecs[i].msg, vecs[i].expDig);
      checkOutput(vecs[i].name, vecs[i].expLat, (i == 1) ? 20 : 0);
      checkVal({vecs[i].name, ":writes"}, writeCount - wBefore, 8);
      checkVal({vecs[i].name, ":hashes"}, hashCount - hBefore, 1);
      checkVal({vecs[i].name, ":core_in"}, coreInBlk, vecs[i].msg);
    end
    checkVal("write_order", writeOrderErr, 0);
    checkVal("write_while_busy", writeWhileBusy, 0);
    checkVal("hash_while_busy", hashWhileBusy, 0);
    checkVal("read_while_busy", readWhileBusy, 0);

    // msg_valid held high through a whole transaction, then a back-to-back block.
    holdCfg = 0;
    busyCfg = 3;
    msgA = mkMsg(32'h12345678, 32'h9);
    msgB = mkMsg(32'h0BADF00D, 32'h10001);
    wBefore = writeCount;
    aBefore = acceptCount;
    applyStimulus(msgA, digestOf(msgA));
    msg_data  = msgB;
    msg_valid = 1'b1;
    readyLeak = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!dig_valid && msg_ready) readyLeak++;
    end while (!dig_valid && n < 400);
    checkVal("t3:ready_leak", readyLeak, 0);
    checkVal("t3:first_valid", dig_valid, 1);
    checkVal("t3:first_data", dig_data, digestOf(msgA));
    if (expQ.size() > 0) expQ.delete(0);
    checkVal("t3:done_ready_low", msg_ready, 0);
    dig_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dig_ready = 1'b0;
    checkVal("t3:idle_window", msg_ready, 1);
    expQ.push_back(digestOf(msgB));
    @(posedge clk);
    #1;
    msg_valid = 1'b0;
    checkVal("t3:second_busy", busy, 1);
    checkOutput("t3_second", 22, 0);
    checkVal("t3:accepts", acceptCount - aBefore, 2);
    checkVal("t3:writes", writeCount - wBefore, 16);

    // Reset in the middle of the read-back.
    msgA = mkMsg(32'h55AA55AA, 32'h01010101);
    applyStimulus(msgA, digestOf(msgA));
    n = 0;
    while (!(ph_opcode == OP_READ && ph_addr == 3'd3) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkVal("t5:reached_read3", (ph_opcode == OP_READ && ph_addr == 3'd3), 1);
    rst = 1'b1;
    #1;
    checkVal("t5:busy", busy, 0);
    checkVal("t5:dig_data", dig_data, 0);
    checkVal("t5:dig_valid", dig_valid, 0);
    checkVal("t5:ph_opcode", ph_opcode, OP_NONE);
    checkVal("t5:msg_ready", msg_ready, 1);
    expQ.delete();
    @(negedge clk);
    rst = 1'b0;
    msgB = mkMsg(32'h76543210, 32'h0F0F0F0F);
    applyStimulus(msgB, digestOf(msgB));
    checkOutput("t5_after", 22, 0);

`ifdef PHOTON_DRV_TIMEOUT_EN
    busyCfg = 100000;
    applyStimulus(mkMsg(32'h1, 32'h1), '0);
    checkOutput("t6_timeout", 28, 0);
    checkVal("t6:err", err, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkVal("t6:err_cleared", err, 0);
    @(negedge clk);
    rst = 1'b0;
    busyCfg = 1;
`else
    checkVal("err_tied_low", err, 0);
`endif

    lat = expQ.size();
    checkVal("scoreboard_drained", lat, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
